clk_div_gen: RTL

Multi-channel, runtime-programmable clock divider. It generates CHANNELS independent 50 %-duty divided clock levels from the 100 MHz system clock, for example the 66.667 kHz SPI/servo timebase. Each channel's half-period is reloaded through a valid/ready config port and applied glitch-free at a period boundary. A common sync pulse phase-aligns all channels.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_ch.sv | 91 +++++++++
 rtl/clk_div_gen.sv | 63 ++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and per-channel state type for the clk_div_gen divider.
// Optional strobe outputs are enabled by defining CLK_DIV_STROBE_EN.
package clk_div_pkg;

    localparam int CLK_DIV_CNT_W        = 16;
    localparam int CLK_DIV_DEFAULT_HALF = 750;

    typedef struct packed {
        logic [CLK_DIV_CNT_W-1:0] cnt;
        logic [CLK_DIV_CNT_W-1:0] act;
        logic [CLK_DIV_CNT_W-1:0] shd;
        logic                     pend;
        logic                     clk_out;
    } clk_div_ch_state_t;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: half-period counter, shadow/apply of new half-periods, strobes.
// rise_stb/fall_stb exist only when CLK_DIV_STROBE_EN is defined.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = CLK_DIV_CNT_W,
    parameter int DEFAULT_HALF = CLK_DIV_DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    output logic             pend,
    output logic             clk_out
`ifdef CLK_DIV_STROBE_EN
    ,
    output logic             rise_stb,
    output logic             fall_stb
`endif
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shd;
    logic             terminal;
    logic             clk_nxt;

    assign terminal = (cnt == act - 1'b1);

    always_comb begin
        clk_nxt = clk_out;
        if (!en || sync) begin
            clk_nxt = 1'b0;
        end else if (terminal) begin
            clk_nxt = ~clk_out;
        end
    end

    // New half-periods only take effect at the end of a full period (falling toggle),
    // so every period keeps 50 % duty; idle channels or sync apply them immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            act     <= CNT_W'(DEFAULT_HALF);
            shd     <= CNT_W'(DEFAULT_HALF);
            pend    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            clk_out <= clk_nxt;
            if (!en || sync || terminal) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (en && sync) begin
                if (load) begin
                    act  <= load_half;
                    shd  <= load_half;
                    pend <= 1'b0;
                end else if (pend) begin
                    act  <= shd;
                    pend <= 1'b0;
                end
            end else begin
                if (pend && (!en || (terminal && clk_out))) begin
                    act  <= shd;
                    pend <= 1'b0;
                end
                if (load) begin
                    shd  <= load_half;
                    pend <= 1'b1;
                end
            end
        end
    end

`ifdef CLK_DIV_STROBE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            rise_stb <= clk_nxt & ~clk_out;
            fall_stb <= ~clk_nxt & clk_out;
        end
    end
`endif

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable 50 %-duty clock divider with cfg port and common sync.
// Define CLK_DIV_STROBE_EN to add the rise_stb/fall_stb outputs.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter  int CHANNELS     = 2,
    parameter  int CNT_W        = CLK_DIV_CNT_W,
    parameter  int DEFAULT_HALF = CLK_DIV_DEFAULT_HALF,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_half,
    output logic [CHANNELS-1:0] clk_out
`ifdef CLK_DIV_STROBE_EN
    ,
    output logic [CHANNELS-1:0] rise_stb,
    output logic [CHANNELS-1:0] fall_stb
`endif
);

    logic [CHANNELS-1:0]  pend;
    logic [2**CH_W-1:0]   pend_ext;
    logic [CNT_W-1:0]     half_eff;
    logic                 xfer;

    // Unused channel addresses read as never-pending, so they are accepted and dropped.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[CHANNELS-1:0]   = pend;
    end

    assign cfg_ready = ~pend_ext[cfg_ch];
    assign xfer      = cfg_valid && cfg_ready;
    assign half_eff  = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (ch_en[i]),
            .sync      (sync),
            .load      (xfer && (cfg_ch == CH_W'(i))),
            .load_half (half_eff),
            .pend      (pend[i]),
            .clk_out   (clk_out[i])
`ifdef CLK_DIV_STROBE_EN
            ,
            .rise_stb  (rise_stb[i]),
            .fall_stb  (fall_stb[i])
`endif
        );
    end

endmodule
